ln_arbiter: RTL and testbench
=============================

LN_ARBITER -- requirements
Module: ln_arbiter

Interface
REQ-001 SHALL have parameter data_size, default 32, meaning the operand and result width.
REQ-002 SHALL have parameter num_req, default 4, meaning the number of requesters sharing one ln unit (2..8).
REQ-003 SHALL have parameter clear_cycles, default 2, meaning the length of the ln-unit clear pulse in cycles (>=1).
REQ-004 SHALL have parameter timeout_cycles, default 64, meaning the maximum wait for an ln result.
REQ-005 SHALL provide ports: clock_i in 1 single clock; reset_n_i in 1 asynchronous active-low reset.
REQ-006 SHALL provide ports: req_data_i in num_req*data_size, packed operands (requester k at bits [k*data_size +: data_size]); req_valid_i in num_req; req_ready_o out num_req.
REQ-007 SHALL provide ports: ln_data_o out data_size, operand to ln unit; ln_data_valid_o out 1; ln_clear_n_o out 1, active-low re-arm of ln unit; ln_result_i in data_size; ln_result_valid_i in 1.
REQ-008 SHALL provide ports: rsp_data_o out data_size; rsp_err_o out 1; rsp_valid_o out num_req, one-hot; rsp_ready_i in num_req; busy_o out 1; timeout_o out 1, single-cycle pulse.

Function
REQ-009 SHALL implement FSM states IDLE, CLEAR, WAIT, RESP; busy_o = 1 in every state except IDLE.
REQ-010 In IDLE with any req_valid_i set, SHALL grant round-robin, searching from (last_grant+1) mod num_req upward with wrap; after reset the search starts at requester 0.
REQ-011 SHALL assert req_ready_o only for the granted requester, only in the IDLE cycle of grant; the operand is captured on that cycle.
REQ-012 Captured operand equal to zero SHALL bypass the ln unit: go directly to RESP with rsp_data_o = 0 and rsp_err_o = 1.
REQ-013 Otherwise SHALL go to CLEAR and hold ln_clear_n_o = 0 for exactly clear_cycles cycles, then enter WAIT.
REQ-014 In WAIT SHALL hold ln_data_o = captured operand and ln_data_valid_o = 1 continuously.
REQ-015 ln_data_o SHALL hold the captured operand stable from CLEAR entry until RESP exit.
REQ-016 In WAIT, on ln_result_valid_i = 1, SHALL register ln_result_i into rsp_data_o, set rsp_err_o = 0, and enter RESP next cycle.
REQ-017 In WAIT SHALL count cycles; if timeout_cycles elapse without ln_result_valid_i, SHALL pulse timeout_o for one cycle and enter RESP with rsp_data_o = all ones and rsp_err_o = 1.
REQ-018 Result and timeout in the same cycle SHALL resolve in favour of the result, with no timeout_o pulse.
REQ-019 In RESP SHALL drive rsp_valid_o[grant] = 1 with rsp_data_o and rsp_err_o stable until rsp_ready_i[grant] = 1.
REQ-020 On that handshake SHALL update last_grant = grant and return to IDLE; ready bits of other requesters SHALL be ignored.
REQ-021 Latency: acceptance at cycle T SHALL give ln_data_valid_o high at T+1+clear_cycles; a result sampled at cycle W SHALL give rsp_valid_o high at W+1.
REQ-022 The zero-bypass path SHALL give rsp_valid_o high at T+1.
REQ-023 Requesters dropping req_valid_i while not granted SHALL cause no state change.
REQ-024 ln_result_valid_i outside WAIT SHALL be ignored.
REQ-025 SHALL accept no new request until the RESP handshake completes, so there is one operation in flight at most.

Reset
REQ-026 While reset_n_i = 0 all outputs SHALL be 0 except ln_clear_n_o = 0; state = IDLE, last_grant pointer = num_req-1, counters = 0.
REQ-027 Reset asserted mid-operation SHALL abort immediately without emitting rsp_valid_o.
REQ-028 After reset release ln_clear_n_o SHALL go to 1 on the first clock edge.

Verification
REQ-029 Single request: req_valid_i = 4'b0010 with operand 32'h2000_0000, ln result returned 10 cycles after ln_data_valid_o -> req_ready_o = 4'b0010 at T, ln_clear_n_o low T+1..T+2, ln_data_valid_o high from T+3, rsp_valid_o = 4'b0010 one cycle after the result, rsp_err_o = 0.
REQ-030 Fairness: all four req_valid_i held high for 8 operations -> grant order 0,1,2,3,0,1,2,3.
REQ-031 Zero operand on requester 2 -> rsp_valid_o = 4'b0100 at T+1, rsp_data_o = 0, rsp_err_o = 1, ln_clear_n_o never low.
REQ-032 No ln_result_valid_i for 64 WAIT cycles -> one-cycle timeout_o pulse, rsp_data_o = 32'hFFFF_FFFF, rsp_err_o = 1.
REQ-033 rsp_ready_i held 0 for 5 cycles in RESP with other requests pending -> rsp_valid_o and data stable, no req_ready_o until the handshake.
REQ-034 reset_n_i pulsed low during WAIT -> outputs at reset values asynchronously, no response, next grant goes to requester 0.

Source files
------------

// File: rtl/ln_arbiter.sv
// ln_arbiter: round-robin arbiter that shares one ln (natural log) unit
// between num_req requesters. It keeps one operation in flight at a time:
// grant -> clear (re-arm the ln unit) -> wait for the result -> respond.
// Zero operands are answered straight away with an error flag. A missing
// ln result is answered with all ones plus an error once the wait expires.
module ln_arbiter #(
  parameter int data_size      = 32,
  parameter int num_req        = 4,
  parameter int clear_cycles   = 2,
  parameter int timeout_cycles = 64
) (
  input  logic                           clock_i,
  input  logic                           reset_n_i,
  input  logic [num_req*data_size-1:0]   req_data_i,
  input  logic [num_req-1:0]             req_valid_i,
  output logic [num_req-1:0]             req_ready_o,
  output logic [data_size-1:0]           ln_data_o,
  output logic                           ln_data_valid_o,
  output logic                           ln_clear_n_o,
  input  logic [data_size-1:0]           ln_result_i,
  input  logic                           ln_result_valid_i,
  output logic [data_size-1:0]           rsp_data_o,
  output logic                           rsp_err_o,
  output logic [num_req-1:0]             rsp_valid_o,
  input  logic [num_req-1:0]             rsp_ready_i,
  output logic                           busy_o,
  output logic                           timeout_o
);

  localparam int IDX_W = $clog2(num_req);
  localparam int CLR_W = $clog2(clear_cycles + 1);
  localparam int TMO_W = $clog2(timeout_cycles + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [IDX_W-1:0]      r_last_grant;
  logic [IDX_W-1:0]      r_grant;
  logic [IDX_W-1:0]      w_grant_idx;
  logic                  w_any_req;
  logic [data_size-1:0]  w_req_operand;
  logic                  w_req_zero;
  logic [data_size-1:0]  r_operand;
  logic [data_size-1:0]  r_rsp_data;
  logic                  r_rsp_err;
  logic                  r_timeout;
  logic                  r_clear_n;
  logic [CLR_W-1:0]      r_clr_cnt;
  logic [TMO_W-1:0]      r_wait_cnt;
  logic                  w_clr_done;
  logic                  w_tmo_hit;
  logic                  w_rsp_hs;

  assign w_req_zero = (w_req_operand == '0);
  assign w_clr_done = (int'(r_clr_cnt) == clear_cycles - 1);
  assign w_tmo_hit  = (int'(r_wait_cnt) == timeout_cycles - 1);
  assign w_rsp_hs   = rsp_ready_i[r_grant];

  // Round-robin search starting just after the last completed grant.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    idx           = 0;
    w_any_req     = 1'b0;
    w_grant_idx   = '0;
    w_req_operand = '0;
    for (int i = 1; i <= num_req; i++) begin
      idx = (int'(r_last_grant) + i) % num_req;
      if (!w_any_req && req_valid_i[idx]) begin
        w_any_req     = 1'b1;
        w_grant_idx   = IDX_W'(idx);
        w_req_operand = req_data_i[idx*data_size +: data_size];
      end
    end
  end

  // State register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n_i) r_state <= ST_IDLE;
    else            r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_next_state = w_req_zero ? ST_RESP : ST_CLEAR;
      ST_CLEAR: if (w_clr_done) w_next_state = ST_WAIT;
      ST_WAIT:  if (ln_result_valid_i || w_tmo_hit) w_next_state = ST_RESP;
      ST_RESP:  if (w_rsp_hs) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, counters, response registers, pointer.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_last_grant <= IDX_W'(num_req - 1);
      r_grant      <= '0;
      r_operand    <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_timeout    <= 1'b0;
      r_clear_n    <= 1'b0;
      r_clr_cnt    <= '0;
      r_wait_cnt   <= '0;
    end else begin
      // The clear pulse is registered so it spans exactly the CLEAR cycles
      // and rises on the first edge after reset.
      r_clear_n <= (w_next_state != ST_CLEAR);
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant    <= w_grant_idx;
            r_operand  <= w_req_operand;
            r_clr_cnt  <= '0;
            r_wait_cnt <= '0;
            if (w_req_zero) begin
              r_rsp_data <= '0;
              r_rsp_err  <= 1'b1;
            end
          end
        end
        ST_CLEAR: r_clr_cnt <= r_clr_cnt + CLR_W'(1);
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + TMO_W'(1);
          // A result arriving on the last wait cycle still wins.
          if (ln_result_valid_i) begin
            r_rsp_data <= ln_result_i;
            r_rsp_err  <= 1'b0;
          end else if (w_tmo_hit) begin
            r_rsp_data <= '1;
            r_rsp_err  <= 1'b1;
            r_timeout  <= 1'b1;
          end
        end
        ST_RESP: if (w_rsp_hs) r_last_grant <= r_grant;
        default: ;
      endcase
    end
  end

  // Ready is gated by reset so nothing is offered while reset is held.
  assign req_ready_o     = (r_state == ST_IDLE && w_any_req && reset_n_i)
                           ? (num_req'(1) << w_grant_idx) : '0;
  assign ln_data_o       = r_operand;
  assign ln_data_valid_o = (r_state == ST_WAIT);
  assign ln_clear_n_o    = r_clear_n;
  assign rsp_data_o      = r_rsp_data;
  assign rsp_err_o       = r_rsp_err;
  assign rsp_valid_o     = (r_state == ST_RESP) ? (num_req'(1) << r_grant) : '0;
  assign busy_o          = (r_state != ST_IDLE);
  assign timeout_o       = r_timeout;

endmodule

// File: tb/tb_ln_arbiter.sv
// tb_ln_arbiter: directed bench for ln_arbiter with default parameters.
// Inputs change on the falling edge; outputs are sampled there or 1ns after.
module tb_ln_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]    req_valid_i;
  logic [NR-1:0]    req_ready_o;
  logic [DW-1:0]    ln_data_o;
  logic             ln_data_valid_o;
  logic             ln_clear_n_o;
  logic [DW-1:0]    ln_result_i;
  logic             ln_result_valid_i;
  logic [DW-1:0]    rsp_data_o;
  logic             rsp_err_o;
  logic [NR-1:0]    rsp_valid_o;
  logic [NR-1:0]    rsp_ready_i;
  logic             busy_o;
  logic             timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  ln_arbiter #(
    .data_size(DW), .num_req(NR), .clear_cycles(2), .timeout_cycles(64)
  ) dut (
    .clock_i          (clk),
    .reset_n_i        (rst_n),
    .req_data_i       (req_data_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .ln_data_o        (ln_data_o),
    .ln_data_valid_o  (ln_data_valid_o),
    .ln_clear_n_o     (ln_clear_n_o),
    .ln_result_i      (ln_result_i),
    .ln_result_valid_i(ln_result_valid_i),
    .rsp_data_o       (rsp_data_o),
    .rsp_err_o        (rsp_err_o),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .busy_o           (busy_o),
    .timeout_o        (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One operation with a prompt ln result; starts and ends on a falling edge.
  task automatic do_op(input string tag, input logic [NR-1:0] exp_grant,
                       input logic [DW-1:0] exp_operand, input logic [DW-1:0] res);
    int n;
    #1;
    check({tag, "_ready"}, req_ready_o, exp_grant);
    @(negedge clk);
    n = 0;
    while (!ln_data_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ln_valid"}, ln_data_valid_o, 1'b1);
    check({tag, "_ln_data"}, ln_data_o, exp_operand);
    ln_result_i       = res;
    ln_result_valid_i = 1'b1;
    @(negedge clk);
    ln_result_valid_i = 1'b0;
    check({tag, "_rsp_valid"}, rsp_valid_o, exp_grant);
    check({tag, "_rsp_data"}, rsp_data_o, res);
    check({tag, "_rsp_err"}, rsp_err_o, 1'b0);
    rsp_ready_i = exp_grant;
    @(negedge clk);
    rsp_ready_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] order [8];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    rst_n             = 1'b0;
    req_valid_i       = '1;
    ln_result_i       = '0;
    ln_result_valid_i = 1'b0;
    rsp_ready_i       = '0;
    for (int k = 0; k < NR; k++) req_data_i[k*DW +: DW] = DW'(k + 1) << 28;

    // Reset values while reset is held, with requests present.
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready_o, 0);
    check("rst_ln_valid", ln_data_valid_o, 0);
    check("rst_clear_n", ln_clear_n_o, 0);
    check("rst_ln_data", ln_data_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_data", {rsp_data_o, rsp_err_o}, 0);
    check("rst_busy_tmo", {busy_o, timeout_o}, 0);
    rst_n       = 1'b1;
    req_valid_i = '0;
    @(negedge clk);
    check("rel_clear_n", ln_clear_n_o, 1);
    check("rel_busy", busy_o, 0);

    // Fairness: all requesters active for eight operations.
    req_valid_i = '1;
    for (int i = 0; i < 8; i++) begin
      int g;
      g = (i % 4);
      do_op($sformatf("fair%0d", i), order[i], DW'(g + 1) << 28, 32'h0100_0000 + DW'(i));
    end
    req_valid_i = '0;

    // Single request on requester 1 with cycle-exact latency checks.
    req_valid_i = 4'b0010;
    req_data_i[1*DW +: DW] = 32'h2000_0000;
    #1;
    check("single_ready", req_ready_o, 4'b0010);
    check("single_busy_t", busy_o, 0);
    @(negedge clk);                    // T+1
    req_valid_i = '0;
    check("single_clr_t1", ln_clear_n_o, 0);
    check("single_busy_t1", busy_o, 1);
    check("single_data_t1", ln_data_o, 32'h2000_0000);
    ln_result_i       = 32'hDEAD_BEEF; // result outside WAIT must be ignored
    ln_result_valid_i = 1'b1;
    @(negedge clk);                    // T+2
    ln_result_valid_i = 1'b0;
    check("single_clr_t2", ln_clear_n_o, 0);
    check("single_lnv_t2", ln_data_valid_o, 0);
    @(negedge clk);                    // T+3
    check("single_clr_t3", ln_clear_n_o, 1);
    check("single_lnv_t3", ln_data_valid_o, 1);
    check("single_rspv_t3", rsp_valid_o, 0);
    repeat (10) @(negedge clk);        // T+13: result returned
    check("single_lnv_t13", ln_data_valid_o, 1);
    check("single_rspv_t13", rsp_valid_o, 0);
    ln_result_i       = 32'h0ABC_0123;
    ln_result_valid_i = 1'b1;
    @(negedge clk);                    // T+14
    ln_result_valid_i = 1'b0;
    check("single_rsp_valid", rsp_valid_o, 4'b0010);
    check("single_rsp_data", rsp_data_o, 32'h0ABC_0123);
    check("single_rsp_err", rsp_err_o, 0);
    check("single_tmo", timeout_o, 0);
    check("single_data_resp", ln_data_o, 32'h2000_0000);
    rsp_ready_i = 4'b0010;
    @(negedge clk);
    rsp_ready_i = '0;
    check("single_done", {busy_o, rsp_valid_o}, 0);

    // Zero operand on requester 2 bypasses the ln unit.
    req_data_i[2*DW +: DW] = '0;
    req_valid_i = 4'b0100;
    #1;
    check("zero_ready", req_ready_o, 4'b0100);
    @(negedge clk);                    // T+1
    req_valid_i = '0;
    check("zero_rsp_valid", rsp_valid_o, 4'b0100);
    check("zero_rsp_data", rsp_data_o, 0);
    check("zero_rsp_err", rsp_err_o, 1);
    check("zero_clear_n", ln_clear_n_o, 1);
    rsp_ready_i = 4'b0100;
    @(negedge clk);
    rsp_ready_i = '0;
    check("zero_done", busy_o, 0);

    // Timeout on requester 0, then stall the response with others pending.
    req_data_i[0*DW +: DW] = 32'h1000_0000;
    req_valid_i = 4'b0001;
    #1;
    check("tmo_ready", req_ready_o, 4'b0001);
    @(negedge clk);
    req_valid_i = '0;
    repeat (2) @(negedge clk);         // first WAIT cycle
    check("tmo_wait0", ln_data_valid_o, 1);
    repeat (63) @(negedge clk);        // 64th WAIT cycle
    check("tmo_w63_pulse", timeout_o, 0);
    check("tmo_w63_rspv", rsp_valid_o, 0);
    check("tmo_w63_lnv", ln_data_valid_o, 1);
    @(negedge clk);
    check("tmo_pulse", timeout_o, 1);
    check("tmo_rsp_valid", rsp_valid_o, 4'b0001);
    check("tmo_rsp_data", rsp_data_o, 32'hFFFF_FFFF);
    check("tmo_rsp_err", rsp_err_o, 1);
    req_valid_i = 4'b1110;
    rsp_ready_i = 4'b1110;             // other ready bits must be ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_rspv", i), rsp_valid_o, 4'b0001);
      check($sformatf("stall%0d_data", i), {rsp_data_o, rsp_err_o}, {32'hFFFF_FFFF, 1'b1});
      check($sformatf("stall%0d_ready", i), {req_ready_o, timeout_o}, 0);
    end
    rsp_ready_i = 4'b0001;
    @(negedge clk);
    rsp_ready_i = '0;
    #1;
    check("stall_next_grant", req_ready_o, 4'b0010);

    // Reset asserted during WAIT aborts the operation.
    @(negedge clk);
    req_valid_i = '0;
    repeat (2) @(negedge clk);
    check("abort_in_wait", ln_data_valid_o, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_lnv", ln_data_valid_o, 0);
    check("abort_clear_n", ln_clear_n_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_outs", {ln_data_o, rsp_data_o, rsp_valid_o}, 0);
    ln_result_i       = 32'h5555_5555;
    ln_result_valid_i = 1'b1;
    rsp_ready_i       = '1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("abort_rspv%0d", i), rsp_valid_o, 0);
    end
    rst_n             = 1'b1;
    ln_result_valid_i = 1'b0;
    rsp_ready_i       = '0;
    req_valid_i       = '1;
    do_op("post_rst", 4'b0001, 32'h1000_0000, 32'h0000_0777);
    req_valid_i = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
